// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for N common-anode seven-segment digits.
// One shared BCD decoder is fed one digit per slot. Each slot opens with a
// blanking guard (all anodes off) and then enables the selected anode. New
// frames are loaded into a pending buffer and swapped in only at a frame
// boundary, so a displayed frame never tears.
module display_scan_controller #(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned SLOT_CYCLES  = 50000,
   parameter int unsigned GUARD_CYCLES = 500
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Load,
   input  logic [4*N_DIGITS-1:0] Digits,
   input  logic [N_DIGITS-1:0]   DP,
   input  logic                  LZBlank,
   output logic                  LoadAck,
   output logic [3:0]            BCD,
   output logic                  SegBlank,
   output logic                  DecimalPoint,
   output logic [N_DIGITS-1:0]   Anode
);

   localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   typedef enum logic [0:0] {StGuard, StDrive} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [4*N_DIGITS-1:0] act_digits_q, act_digits_d;
   logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic                  act_lz_q, act_lz_d;
   logic [4*N_DIGITS-1:0] pend_digits_q, pend_digits_d;
   logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic                  pend_lz_q, pend_lz_d;
   logic                  pend_valid_q, pend_valid_d;
   logic                  load_ack_q, load_ack_d;
   logic [3:0]            bcd_q, bcd_d;
   logic                  seg_blank_q, seg_blank_d;
   logic                  dec_point_q, dec_point_d;
   logic [N_DIGITS-1:0]   anode_q, anode_d;
   logic                  frame_end;
   logic [N_DIGITS-1:0]   blank_vec;
   logic                  zero_run;
   logic [3:0]            sel_code;

   // Slot timing FSM, frame swap and pending-frame capture.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CntW'(1);
      idx_d         = idx_q;
      frame_end     = 1'b0;
      act_digits_d  = act_digits_q;
      act_dp_d      = act_dp_q;
      act_lz_d      = act_lz_q;
      pend_digits_d = pend_digits_q;
      pend_dp_d     = pend_dp_q;
      pend_lz_d     = pend_lz_q;
      pend_valid_d  = pend_valid_q;
      load_ack_d    = 1'b0;

      unique case (state_q)
         StGuard: begin
            if (cnt_q == CntW'(GUARD_CYCLES - 1)) state_d = StDrive;
         end
         StDrive: begin
            if (cnt_q == CntW'(SLOT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = StGuard;
               if (idx_q == IdxW'(N_DIGITS - 1)) begin
                  idx_d     = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         default: state_d = StGuard;
      endcase

      if (frame_end && pend_valid_q) begin
         act_digits_d = pend_digits_q;
         act_dp_d     = pend_dp_q;
         act_lz_d     = pend_lz_q;
         pend_valid_d = 1'b0;
         load_ack_d   = 1'b1;
      end

      // A load on the swap cycle lands in pending for the following frame.
      if (Load) begin
         pend_digits_d = Digits;
         pend_dp_d     = DP;
         pend_lz_d     = LZBlank;
         pend_valid_d  = 1'b1;
      end
   end

   // Leading-zero mask: digit i blanks when it and every more-significant digit is 0.
   always_comb begin
      blank_vec = '0;
      zero_run  = act_lz_d;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run & (act_digits_d[4*i +: 4] == 4'd0);
         blank_vec[i] = zero_run;
      end
   end

   // Output decode from next-state values so every output is a plain flop.
   always_comb begin
      sel_code    = act_digits_d[4*int'(idx_d) +: 4];
      seg_blank_d = blank_vec[idx_d];
      bcd_d       = blank_vec[idx_d] ? 4'd0 : sel_code;
      dec_point_d = act_dp_d[idx_d];
      anode_d     = '1;
      if (state_d == StDrive) anode_d = ~(N_DIGITS'(1) << idx_d);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= StGuard;
         cnt_q         <= '0;
         idx_q         <= '0;
         act_digits_q  <= '0;
         act_dp_q      <= '0;
         act_lz_q      <= 1'b0;
         pend_digits_q <= '0;
         pend_dp_q     <= '0;
         pend_lz_q     <= 1'b0;
         pend_valid_q  <= 1'b0;
         load_ack_q    <= 1'b0;
         bcd_q         <= 4'd0;
         seg_blank_q   <= 1'b1;
         dec_point_q   <= 1'b0;
         anode_q       <= '1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         act_digits_q  <= act_digits_d;
         act_dp_q      <= act_dp_d;
         act_lz_q      <= act_lz_d;
         pend_digits_q <= pend_digits_d;
         pend_dp_q     <= pend_dp_d;
         pend_lz_q     <= pend_lz_d;
         pend_valid_q  <= pend_valid_d;
         load_ack_q    <= load_ack_d;
         bcd_q         <= bcd_d;
         seg_blank_q   <= seg_blank_d;
         dec_point_q   <= dec_point_d;
         anode_q       <= anode_d;
      end
   end

   assign LoadAck      = load_ack_q;
   assign BCD          = bcd_q;
   assign SegBlank     = seg_blank_q;
   assign DecimalPoint = dec_point_q;
   assign Anode        = anode_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with 4 digits, 8-cycle slots, 2-cycle guard.
module tb_display_scan_controller;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Load = 1'b0;
   logic [15:0] Digits = '0;
   logic [3:0]  DP = '0;
   logic        LZBlank = 1'b0;
   logic        LoadAck;
   logic [3:0]  BCD;
   logic        SegBlank;
   logic        DecimalPoint;
   logic [3:0]  Anode;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] ld_val [4];
   logic [3:0]  ld_dpa [4];
   logic        ld_lza [4];
   int          ld_cyc [4];

   logic        inv_en = 1'b0;
   logic        have_prev = 1'b0;
   logic [3:0]  prev_an;
   logic [3:0]  prev_bcd;

   display_scan_controller #(
      .N_DIGITS    (4),
      .SLOT_CYCLES (8),
      .GUARD_CYCLES(2)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Load        (Load),
      .Digits      (Digits),
      .DP          (DP),
      .LZBlank     (LZBlank),
      .LoadAck     (LoadAck),
      .BCD         (BCD),
      .SegBlank    (SegBlank),
      .DecimalPoint(DecimalPoint),
      .Anode       (Anode)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks ncyc cycles of one slot starting at its first cycle; optional one-cycle load.
   task automatic check_slot(input int d, input logic [3:0] bcd, input logic sb,
                             input logic dp, input logic ack, input logic do_ld,
                             input int ld_c, input logic [15:0] ld_v,
                             input logic [3:0] ld_dpv, input logic ld_lzv, input int ncyc);
      logic [3:0] exp_an;
      logic       exp_ack;
      for (int c = 0; c < ncyc; c++) begin
         Load    = do_ld && (c == ld_c);
         Digits  = ld_v;
         DP      = ld_dpv;
         LZBlank = ld_lzv;
         exp_an  = (c < 2) ? 4'hF : ~(4'b0001 << d);
         exp_ack = (c == 0) ? ack : 1'b0;
         chk($sformatf("d%0d c%0d anode", d, c), {12'h0, Anode}, {12'h0, exp_an});
         chk($sformatf("d%0d c%0d bcd", d, c), {12'h0, BCD}, {12'h0, bcd});
         chk($sformatf("d%0d c%0d segblank", d, c), {15'h0, SegBlank}, {15'h0, sb});
         chk($sformatf("d%0d c%0d dp", d, c), {15'h0, DecimalPoint}, {15'h0, dp});
         chk($sformatf("d%0d c%0d loadack", d, c), {15'h0, LoadAck}, {15'h0, exp_ack});
         @(negedge Clk);
      end
      Load = 1'b0;
   endtask

   task automatic check_frame(input logic [15:0] bcd, input logic [3:0] sb,
                              input logic [3:0] dp, input logic ack, input logic [3:0] ldm);
      for (int d = 0; d < 4; d++) begin
         check_slot(d, bcd[4*d +: 4], sb[d], dp[d], ack && (d == 0), ldm[d], ld_cyc[d],
                    ld_val[d], ld_dpa[d], ld_lza[d], 8);
      end
   endtask

   task automatic set_ld(input int s, input int c, input logic [15:0] v,
                         input logic [3:0] dpv, input logic lz);
      ld_cyc[s] = c;
      ld_val[s] = v;
      ld_dpa[s] = dpv;
      ld_lza[s] = lz;
   endtask

   // Holds reset for n edges, checks reset values, then checks the whole first frame.
   task automatic do_reset(input int n);
      logic [3:0] exp_an;
      Load  = 1'b0;
      Reset = 1'b1;
      repeat (n) @(negedge Clk);
      chk("rst anode", {12'h0, Anode}, 16'h000F);
      chk("rst bcd", {12'h0, BCD}, 16'h0000);
      chk("rst segblank", {15'h0, SegBlank}, 16'h0001);
      chk("rst dp", {15'h0, DecimalPoint}, 16'h0000);
      chk("rst loadack", {15'h0, LoadAck}, 16'h0000);
      Reset = 1'b0;
      @(negedge Clk);
      for (int c = 1; c < 8; c++) begin
         exp_an = (c < 2) ? 4'hF : 4'hE;
         chk($sformatf("f0 d0 c%0d anode", c), {12'h0, Anode}, {12'h0, exp_an});
         chk($sformatf("f0 d0 c%0d bcd", c), {12'h0, BCD}, 16'h0000);
         chk($sformatf("f0 d0 c%0d segblank", c), {15'h0, SegBlank}, 16'h0000);
         chk($sformatf("f0 d0 c%0d loadack", c), {15'h0, LoadAck}, 16'h0000);
         @(negedge Clk);
      end
      for (int d = 1; d < 4; d++) check_slot(d, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, '0,
                                             1'b0, 8);
   endtask

   // Scan-wide invariants: at most one anode low; anode and BCD never move together
   // unless the anodes are going all-off.
   always @(negedge Clk) begin
      if (inv_en) begin
         n_cmp++;
         assert ($countones(~Anode) <= 1) else begin
            n_bad++;
            $error("FAIL inv_onehot: observed Anode=%b expected at most one zero", Anode);
         end
         if (have_prev) begin
            n_cmp++;
            assert (!((Anode !== prev_an) && (BCD !== prev_bcd) && (Anode !== 4'hF))) else begin
               n_bad++;
               $error("FAIL inv_together: observed Anode %b->%b BCD %h->%h expected no joint change",
                      prev_an, Anode, prev_bcd, BCD);
            end
         end
         prev_an   = Anode;
         prev_bcd  = BCD;
         have_prev = 1'b1;
      end
   end

   initial begin
      for (int s = 0; s < 4; s++) set_ld(s, 0, '0, '0, 1'b0);
      inv_en = 1'b1;

      // Reset then one idle frame of zeros.
      do_reset(3);

      // Mid-frame load of 1234 is invisible until the boundary.
      set_ld(1, 3, 16'h1234, 4'b0100, 1'b0);
      check_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 4'b0010);
      check_frame(16'h1234, 4'b0000, 4'b0100, 1'b1, 4'b0000);

      // Pattern repeats; load 0070 with leading-zero blanking.
      set_ld(2, 5, 16'h0070, 4'b0000, 1'b1);
      check_frame(16'h1234, 4'b0000, 4'b0100, 1'b0, 4'b0100);

      // 0070 blanks digits 3,2; then load all zeros with a DP on blanked digit 1.
      set_ld(1, 6, 16'h0000, 4'b0010, 1'b1);
      check_frame(16'h0070, 4'b1100, 4'b0000, 1'b1, 4'b0010);

      // Two loads in one frame: last one wins with a single ack.
      set_ld(0, 3, 16'h1111, 4'b0000, 1'b0);
      set_ld(2, 3, 16'h2222, 4'b0000, 1'b0);
      check_frame(16'h0000, 4'b1110, 4'b0010, 1'b1, 4'b0101);

      // Load on the LoadAck cycle is applied one frame later.
      set_ld(0, 0, 16'h5678, 4'b1000, 1'b0);
      check_frame(16'h2222, 4'b0000, 4'b0000, 1'b1, 4'b0001);

      // Load on the last cycle of the frame goes to the frame after next.
      set_ld(3, 7, 16'h00A5, 4'b0000, 1'b1);
      check_frame(16'h5678, 4'b0000, 4'b1000, 1'b1, 4'b1000);
      check_frame(16'h5678, 4'b0000, 4'b1000, 1'b0, 4'b0000);

      // Code A is shown and stops zero blanking of lower digits.
      check_frame(16'h00A5, 4'b1100, 4'b0000, 1'b1, 4'b0000);

      // Pending load, then reset during DRIVE of digit 2.
      check_slot(0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 3, 16'h4444, 4'b1111, 1'b0, 8);
      check_slot(1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0, 8);
      check_slot(2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0, 5);
      do_reset(1);

      // Pending load was discarded: no ack and zeros remain.
      check_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);

      inv_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
